float_mult_pipe: RTL and testbench

- Parametrised, pipelined IEEE-754-style floating-point multiplier for the CNN datapath. It succeeds the combinational 16-bit multiplier.
- Exponent and mantissa widths are generics. Fixed 3-stage pipeline with valid/ready handshake and backpressure.
- Round-to-nearest-even, special-value handling and status flags.
- Sits between the feature-map/weight buffers and the accumulator.

---
 rtl/float_pkg.sv | 33 +++
 rtl/float_norm_round.sv | 41 ++++
 rtl/float_mult_pipe.sv | 159 +++++++++++++++
 tb/tb_float_mult_pipe.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared definitions for the parametrised floating-point datapath blocks:
// format helpers, operand class encoding and status flag bit positions.
package float_pkg;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } fclass_e;

   localparam int FLAG_INVALID   = 2;
   localparam int FLAG_OVERFLOW  = 1;
   localparam int FLAG_UNDERFLOW = 0;

   function automatic int float_bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic int float_width(input int exp_w, input int man_w);
      return 1 + exp_w + man_w;
   endfunction

   // Canonical quiet NaN: positive, exponent all ones, mantissa MSB set.
   function automatic logic [63:0] float_qnan(input int exp_w, input int man_w);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
      v[man_w - 1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/float_norm_round.sv
// Combinational normalise and round-to-nearest-even of a raw mantissa
// product; shared between the multiplier and the planned adder.
module float_norm_round #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic signed [EXP_W+1:0]   exp_i,
   input  logic        [2*MAN_W+1:0] man_i,
   output logic signed [EXP_W+1:0]   exp_o,
   output logic        [MAN_W-1:0]   man_o
);

   localparam int PW  = 2*MAN_W + 2;
   localparam int XW  = EXP_W + 2;
   localparam int MW1 = MAN_W + 1;
   localparam logic signed [XW-1:0] ONE_X = XW'(1);

   logic [PW-1:0]          shifted;
   logic signed [XW-1:0]   exp_n;
   logic [MAN_W-1:0]       mant;
   logic                   guard;
   logic                   sticky;
   logic                   round_up;
   logic                   carry;
   logic [MAN_W-1:0]       man_r;

   // NOTE: every signal written here gets a value on every path, so no latch is inferred.
   always_comb begin
      // Align so the hidden one always sits in the MSB.
      shifted  = man_i[PW-1] ? man_i : (man_i << 1);
      exp_n    = man_i[PW-1] ? (exp_i + ONE_X) : exp_i;
      mant     = shifted[PW-2 -: MAN_W];
      guard    = shifted[MAN_W];
      sticky   = |shifted[MAN_W-1:0];
      round_up = guard & (sticky | mant[0]);
      {carry, man_r} = {1'b0, mant} + MW1'(round_up);
      man_o    = man_r;
      exp_o    = carry ? (exp_n + ONE_X) : exp_n;
   end

endmodule

// File: rtl/float_mult_pipe.sv
// Three-stage pipelined floating-point multiplier (unpack/multiply,
// normalise/round, pack/special) with valid/ready flow control.
module float_mult_pipe
   import float_pkg::*;
#(
   parameter  int EXP_W = 5,
   parameter  int MAN_W = 10,
   localparam int W     = float_width(EXP_W, MAN_W)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] float_a,
   input  logic [W-1:0] float_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] product,
   output logic [2:0]   flags
);

   localparam int PW = 2*MAN_W + 2;
   localparam int XW = EXP_W + 2;
   localparam logic signed [XW-1:0] BIAS_X     = XW'(float_bias(EXP_W));
   localparam logic signed [XW-1:0] EXP_MAX_X  = XW'((1 << EXP_W) - 1);
   localparam logic signed [XW-1:0] EXP_ZERO_X = '0;
   localparam logic [W-1:0]         QNAN       = W'(float_qnan(EXP_W, MAN_W));

   function automatic fclass_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
      if (e == '0) return CLS_ZERO;
      if (&e)      return (m == '0) ? CLS_INF : CLS_NAN;
      return CLS_NORM;
   endfunction

   // Pipeline occupancy and load enables
   logic s1_valid_q, s2_valid_q, s3_valid_q;
   logic ld1, ld2, ld3;

   assign ld3      = !s3_valid_q | out_ready;
   assign ld2      = !s2_valid_q | ld3;
   assign ld1      = !s1_valid_q | ld2;
   assign in_ready = ld1;

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
      end else begin
         if (ld1) s1_valid_q <= in_valid;
         if (ld2) s2_valid_q <= s1_valid_q;
         if (ld3) s3_valid_q <= s2_valid_q;
      end
   end

   // Stage 1: unpack, classify, exponent sum, mantissa product
   logic                 s1_sign_d;
   logic signed [XW-1:0] s1_exp_d;
   logic [PW-1:0]        s1_man_d;
   fclass_e              s1_cls_a_d, s1_cls_b_d;

   assign s1_sign_d  = float_a[W-1] ^ float_b[W-1];
   assign s1_exp_d   = XW'(float_a[W-2 -: EXP_W]) + XW'(float_b[W-2 -: EXP_W]) - BIAS_X;
   assign s1_man_d   = PW'({1'b1, float_a[MAN_W-1:0]}) * PW'({1'b1, float_b[MAN_W-1:0]});
   assign s1_cls_a_d = classify(float_a[W-2 -: EXP_W], float_a[MAN_W-1:0]);
   assign s1_cls_b_d = classify(float_b[W-2 -: EXP_W], float_b[MAN_W-1:0]);

   logic                 s1_sign_q;
   logic signed [XW-1:0] s1_exp_q;
   logic [PW-1:0]        s1_man_q;
   fclass_e              s1_cls_a_q, s1_cls_b_q;

   // NOTE: datapath registers carry no reset; only the valid bits decide what is live.
   always_ff @(posedge clk) begin
      if (ld1 && in_valid) begin
         s1_sign_q  <= s1_sign_d;
         s1_exp_q   <= s1_exp_d;
         s1_man_q   <= s1_man_d;
         s1_cls_a_q <= s1_cls_a_d;
         s1_cls_b_q <= s1_cls_b_d;
      end
   end

   // Stage 2: normalise and round
   logic signed [XW-1:0] nr_exp;
   logic [MAN_W-1:0]     nr_man;

   float_norm_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_norm_round (
      .exp_i (s1_exp_q),
      .man_i (s1_man_q),
      .exp_o (nr_exp),
      .man_o (nr_man)
   );

   logic                 s2_sign_q;
   logic signed [XW-1:0] s2_exp_q;
   logic [MAN_W-1:0]     s2_man_q;
   fclass_e              s2_cls_a_q, s2_cls_b_q;

   always_ff @(posedge clk) begin
      if (ld2 && s1_valid_q) begin
         s2_sign_q  <= s1_sign_q;
         s2_exp_q   <= nr_exp;
         s2_man_q   <= nr_man;
         s2_cls_a_q <= s1_cls_a_q;
         s2_cls_b_q <= s1_cls_b_q;
      end
   end

   // Stage 3: special values, range checks, pack
   logic [W-1:0] pack_d;
   logic [2:0]   flags_d;
   logic         nan_any, inf_any, zero_any;

   always_comb begin
      nan_any  = (s2_cls_a_q == CLS_NAN)  || (s2_cls_b_q == CLS_NAN);
      inf_any  = (s2_cls_a_q == CLS_INF)  || (s2_cls_b_q == CLS_INF);
      zero_any = (s2_cls_a_q == CLS_ZERO) || (s2_cls_b_q == CLS_ZERO);
      pack_d   = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_man_q};
      flags_d  = '0;
      if (nan_any || (inf_any && zero_any)) begin
         pack_d                = QNAN;
         flags_d[FLAG_INVALID] = 1'b1;
      end else if (inf_any) begin
         pack_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (zero_any) begin
         pack_d = {s2_sign_q, {(W-1){1'b0}}};
      end else if (s2_exp_q >= EXP_MAX_X) begin
         pack_d                 = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_d[FLAG_OVERFLOW] = 1'b1;
      end else if (s2_exp_q <= EXP_ZERO_X) begin
         pack_d                  = {s2_sign_q, {(W-1){1'b0}}};
         flags_d[FLAG_UNDERFLOW] = 1'b1;
      end
   end

   // Output register is cleared so the idle bus reads zero after reset.
   logic [W-1:0] product_q;
   logic [2:0]   flags_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         product_q <= '0;
         flags_q   <= '0;
      end else if (ld3 && s2_valid_q) begin
         product_q <= pack_d;
         flags_q   <= flags_d;
      end
   end

   assign out_valid = s3_valid_q;
   assign product   = product_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_float_mult_pipe.sv
// Self-checking bench for float_mult_pipe: FP16 and FP32 instances checked
// against a real-arithmetic reference model through per-instance scoreboards.
`timescale 1ns/1ps
module tb_float_mult_pipe;

   typedef struct packed {
      logic [31:0] p;
      logic [2:0]  f;
   } res_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        iv16, ir16, ov16, or16;
   logic [15:0] a16, b16, p16;
   logic [2:0]  f16;
   logic        iv32, ir32, ov32, or32;
   logic [31:0] a32, b32, p32;
   logic [2:0]  f32;

   int checks = 0;
   int errors = 0;
   int n_acc16 = 0;
   int n_out16 = 0;
   res_t q16[$];
   res_t q32[$];

   always #10 clk = ~clk;

   float_mult_pipe dut16 (
      .clk(clk), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16),
      .float_a(a16), .float_b(b16), .out_valid(ov16), .out_ready(or16),
      .product(p16), .flags(f16)
   );

   float_mult_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
      .clk(clk), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32),
      .float_a(a32), .float_b(b32), .out_valid(ov32), .out_ready(or32),
      .product(p32), .flags(f32)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic real pow2(input int n);
      real r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else        for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   // Reference: exact real product, then RNE into the target format with flush-to-zero.
   function automatic res_t model(input int E, input int M, input logic [31:0] a, input logic [31:0] b);
      res_t r;
      int bias = (1 << (E - 1)) - 1;
      int emax = (1 << E) - 1;
      int ea = int'(a >> M) & emax;
      int eb = int'(b >> M) & emax;
      int ma = int'(a) & ((1 << M) - 1);
      int mb = int'(b) & ((1 << M) - 1);
      int sg = (int'(a >> (E + M)) ^ int'(b >> (E + M))) & 1;
      bit za = (ea == 0), zb = (eb == 0);
      bit ia = (ea == emax) && (ma == 0), ib = (eb == emax) && (mb == 0);
      bit na = (ea == emax) && (ma != 0), nb = (eb == emax) && (mb != 0);
      logic [31:0] inf_v = 32'(sg << (E + M)) | 32'(emax << M);
      logic [31:0] zero_v = 32'(sg << (E + M));
      real va, vb, v, t, s, rem;
      int e, q, be;
      r.f = 3'b000;
      if (na || nb || (ia && zb) || (ib && za)) begin
         r.p = 32'(emax << M) | 32'(1 << (M - 1));
         r.f = 3'b100;
      end else if (ia || ib) begin
         r.p = inf_v;
      end else if (za || zb) begin
         r.p = zero_v;
      end else begin
         va = (1.0 + real'(ma) / pow2(M)) * pow2(ea - bias);
         vb = (1.0 + real'(mb) / pow2(M)) * pow2(eb - bias);
         v = va * vb;
         e = 0;
         t = 1.0;
         while (v >= 2.0 * t) begin t = t * 2.0; e++; end
         while (v < t) begin t = t / 2.0; e--; end
         s = (v / t) * pow2(M);
         q = $rtoi(s);
         rem = s - real'(q);
         if (rem > 0.5 || (rem == 0.5 && (q % 2) == 1)) q++;
         if (q == (1 << (M + 1))) begin q = q / 2; e++; end
         be = e + bias;
         if (be >= emax) begin
            r.p = inf_v;
            r.f = 3'b010;
         end else if (be <= 0) begin
            r.p = zero_v;
            r.f = 3'b001;
         end else begin
            r.p = zero_v | 32'(be << M) | 32'(q & ((1 << M) - 1));
         end
      end
      return r;
   endfunction

   // Compare process: scoreboard push on input transfer, pop and compare on output transfer.
   initial begin
      bit          hold16 = 0, hold32 = 0;
      logic [15:0] hp16;
      logic [31:0] hp32;
      logic [2:0]  hf16, hf32;
      res_t        e;
      forever begin
         @(negedge clk);
         if (hold16) begin
            check("hold_prod16", 64'(p16), 64'(hp16));
            check("hold_flags16", 64'(f16), 64'(hf16));
         end
         if (hold32) begin
            check("hold_prod32", 64'(p32), 64'(hp32));
            check("hold_flags32", 64'(f32), 64'(hf32));
         end
         if (iv16 && ir16) begin
            q16.push_back(model(5, 10, 32'(a16), 32'(b16)));
            n_acc16++;
         end
         if (iv32 && ir32) q32.push_back(model(8, 23, a32, b32));
         if (ov16 && or16) begin
            if (q16.size() == 0) fail("unexpected_out16");
            else begin
               e = q16.pop_front();
               check("prod16", 64'(p16), 64'(e.p[15:0]));
               check("flags16", 64'(f16), 64'(e.f));
               n_out16++;
            end
         end
         if (ov32 && or32) begin
            if (q32.size() == 0) fail("unexpected_out32");
            else begin
               e = q32.pop_front();
               check("prod32", 64'(p32), 64'(e.p));
               check("flags32", 64'(f32), 64'(e.f));
            end
         end
         hold16 = ov16 && !or16;
         hold32 = ov32 && !or32;
         hp16 = p16; hf16 = f16;
         hp32 = p32; hf32 = f32;
      end
   end

   // Presents one pair and returns 1 ns after the edge that accepted it.
   task automatic send(input bit w32, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      if (w32) begin a32 = a; b32 = b; iv32 = 1'b1; end
      else     begin a16 = a[15:0]; b16 = b[15:0]; iv16 = 1'b1; end
      forever begin
         @(negedge clk);
         if (w32 ? ir32 : ir16) break;
         n++;
         if (n > 200) begin fail("send_timeout"); break; end
      end
      @(posedge clk);
      #1;
      if (w32) iv32 = 1'b0; else iv16 = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q16.size() != 0 || q32.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q16.size() != 0 || q32.size() != 0) fail("drain_timeout");
   endtask

   task automatic latency16(input string name, input logic [15:0] a, input logic [15:0] b);
      int lat = 1;
      send(0, 32'(a), 32'(b));
      while (!ov16 && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check(name, 64'(lat), 64'd3);
   endtask

   typedef struct {
      logic [15:0] a, b, p;
      logic [2:0]  f;
   } vec16_t;

   vec16_t dir16[9] = '{
      '{16'h4400, 16'h4500, 16'h4D00, 3'b000},
      '{16'hC400, 16'h4500, 16'hCD00, 3'b000},
      '{16'h3C01, 16'h3E00, 16'h3E02, 3'b000},
      '{16'h3C01, 16'h3C01, 16'h3C02, 3'b000},
      '{16'h3E00, 16'h3E00, 16'h4080, 3'b000},
      '{16'h7BFF, 16'h7BFF, 16'h7C00, 3'b010},
      '{16'h0400, 16'h0400, 16'h0000, 3'b001},
      '{16'h7C00, 16'h0000, 16'h7E00, 3'b100},
      '{16'h0000, 16'h0000, 16'h0000, 3'b000}
   };

   logic [15:0] bp_a[6] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'hC000, 16'h3555};
   logic [15:0] bp_b[6] = '{16'h4000, 16'h4000, 16'h4000, 16'h3800, 16'h4200, 16'h4248};

   initial begin
      res_t m;
      int   base_acc, base_out, seen;
      logic [31:0] ra, rb;

      reset_n = 1'b0;
      iv16 = 1'b0; iv32 = 1'b0; or16 = 1'b1; or32 = 1'b1;
      a16 = '0; b16 = '0; a32 = '0; b32 = '0;
      #5;
      check("rst_out_valid16", 64'(ov16), 64'd0);
      check("rst_product16", 64'(p16), 64'd0);
      check("rst_flags16", 64'(f16), 64'd0);
      check("rst_out_valid32", 64'(ov32), 64'd0);
      #30 reset_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready16", 64'(ir16), 64'd1);

      // Model pinned to hand-computed results
      foreach (dir16[i]) begin
         m = model(5, 10, 32'(dir16[i].a), 32'(dir16[i].b));
         check("pin_model16_p", 64'(m.p[15:0]), 64'(dir16[i].p));
         check("pin_model16_f", 64'(m.f), 64'(dir16[i].f));
      end
      m = model(8, 23, 32'h40800000, 32'h40A00000);
      check("pin_model32_p", 64'(m.p), 64'h41A00000);

      @(posedge clk); #1;
      latency16("latency_first", 16'h4400, 16'h4500);
      drain();

      // Directed vectors back to back, FP32 in parallel
      @(posedge clk); #1;
      fork
         foreach (dir16[i]) send(0, 32'(dir16[i].a), 32'(dir16[i].b));
         begin
            send(1, 32'h40800000, 32'h40A00000);
            send(1, 32'hC0800000, 32'h40A00000);
         end
      join
      drain();

      // Random operands, FP32 exponents half the time kept near the bias
      @(posedge clk); #1;
      fork
         for (int i = 0; i < 30; i++) send(0, 32'($urandom_range(0, 65535)), 32'($urandom_range(0, 65535)));
         for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 0) begin
               ra[30:23] = 8'($urandom_range(107, 147));
               rb[30:23] = 8'($urandom_range(107, 147));
            end
            send(1, ra, rb);
         end
      join
      drain();

      // Backpressure: full pipe holds three, then releases in order
      @(posedge clk); #1;
      or16 = 1'b0;
      base_acc = n_acc16;
      base_out = n_out16;
      fork
         for (int i = 0; i < 6; i++) send(0, 32'(bp_a[i]), 32'(bp_b[i]));
         begin
            repeat (8) @(negedge clk);
            #1;
            check("bp_accepts", 64'(n_acc16 - base_acc), 64'd3);
            check("bp_in_ready", 64'(ir16), 64'd0);
            check("bp_out_valid", 64'(ov16), 64'd1);
            @(posedge clk); #1;
            or16 = 1'b1;
         end
      join
      drain();
      check("bp_results", 64'(n_out16 - base_out), 64'd6);

      // Asynchronous reset with two pairs in flight
      @(posedge clk); #1;
      send(0, 32'h4400, 32'h4400);
      send(0, 32'h4200, 32'h4200);
      @(posedge clk); #1;
      check("mid_pre_valid", 64'(ov16), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_out_valid", 64'(ov16), 64'd0);
      check("mid_product", 64'(p16), 64'd0);
      q16.delete();
      q32.delete();
      #2 reset_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (ov16) seen++;
      end
      check("mid_no_stale", 64'(seen), 64'd0);
      @(posedge clk); #1;
      latency16("latency_after_reset", 16'h4400, 16'h4500);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
